// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 types, command constants and parity helper
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SEND,
        ST_ACK,
        ST_WAIT_IDLE,
        ST_FINISH
    } ps2_tx_state_e;

    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

    // Parity bit that makes data plus parity contain an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command request/completion bundle for the PS/2 host transmitter
interface ps2_host_tx_if;
    logic       i_valid;
    logic [7:0] i_data;
    logic       o_ready;
    logic       o_busy;
    logic       o_done;
    logic       o_ack_ok;
    logic       o_timeout;

    modport master (
        output i_valid, i_data,
        input  o_ready, o_busy, o_done, o_ack_ok, o_timeout
    );

    modport slave (
        input  i_valid, i_data,
        output o_ready, o_busy, o_done, o_ack_ok, o_timeout
    );
endinterface

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - PS/2 pad synchronizer with falling-edge detect
module ps2_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pad,
    output logic o_level,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Idle PS/2 lines are pulled high, so reset to 1 to avoid a false fall.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync[0] <= i_pad;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_fall  = r_prev & ~r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - host-to-device PS/2 command byte transmitter
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    ps2_host_tx_if.slave       tx,
    input  logic               i_ps2_clk,
    input  logic               i_ps2_data,
    output logic               o_ps2_clk_oe,
    output logic               o_ps2_data_oe
);

    localparam int CNT_W = $clog2(INHIBIT_CYCLES);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    logic w_clk_level;
    logic w_clk_fall;
    logic w_data_level;

    ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_pad   (i_ps2_clk),
        .o_level (w_clk_level),
        .o_fall  (w_clk_fall)
    );

    ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_data_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_pad   (i_ps2_data),
        .o_level (w_data_level),
        .o_fall  ()
    );

    ps2_tx_state_e    r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [TO_W-1:0]  r_tcnt;
    logic [3:0]       r_bitcnt;
    logic [9:0]       r_shift;
    logic             r_ack;
    logic             r_clk_oe;
    logic             r_data_oe;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_ack_ok;
    logic             r_timeout;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_tcnt    <= '0;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_ack     <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ack_ok  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (tx.i_valid && r_ready) begin
                        r_shift  <= {1'b1, odd_parity(tx.i_data), tx.i_data};
                        r_clk_oe <= 1'b1;
                        r_cnt    <= '0;
                        r_ack    <= 1'b0;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_INHIBIT;
                    end
                end

                ST_INHIBIT: begin
                    if (r_cnt == INH_LAST) begin
                        r_data_oe <= 1'b1;
                        r_state   <= ST_REQ;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                // Releasing clk with data held low is the request-to-send.
                ST_REQ: begin
                    r_clk_oe <= 1'b0;
                    r_tcnt   <= '0;
                    r_bitcnt <= '0;
                    r_state  <= ST_SEND;
                end

                ST_SEND, ST_ACK, ST_WAIT_IDLE: begin
                    if (r_tcnt == TO_LAST) begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_ack_ok  <= 1'b0;
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= ST_FINISH;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                        if (r_state == ST_SEND) begin
                            if (w_clk_fall) begin
                                r_data_oe <= ~r_shift[r_bitcnt];
                                r_bitcnt  <= r_bitcnt + 1'b1;
                                if (r_bitcnt == 4'd9) begin
                                    r_state <= ST_ACK;
                                end
                            end
                        end else if (r_state == ST_ACK) begin
                            if (w_clk_fall) begin
                                r_ack   <= ~w_data_level;
                                r_state <= ST_WAIT_IDLE;
                            end
                        end else if (w_clk_level && w_data_level) begin
                            r_ack_ok  <= r_ack;
                            r_timeout <= 1'b0;
                            r_done    <= 1'b1;
                            r_state   <= ST_FINISH;
                        end
                    end
                end

                ST_FINISH: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_ready   <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ps2_clk_oe  = r_clk_oe;
    assign o_ps2_data_oe = r_data_oe;
    assign tx.o_ready    = r_ready;
    assign tx.o_busy     = r_busy;
    assign tx.o_done     = r_done;
    assign tx.o_ack_ok   = r_ack_ok;
    assign tx.o_timeout  = r_timeout;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It sends one command byte to the mouse, e.g. 0xF4 "enable data reporting" or 0xFF "reset".
- It is the opposite direction to the existing Mouse receiver, which only decodes device-to-host packets.
- It sits beside Mouse under the cursor/handwrite display path and shares the ps2_clk/ps2_data open-drain lines.
- It is driven by a small init sequencer, or by the top level after reset.

Parameters:
- INHIBIT_CYCLES, 6000: clocks that ps2_clk is held low before the start bit (120 us at 50 MHz).
- TIMEOUT_CYCLES, 1000000: maximum clocks from clock release to the ACK phase completing (20 ms at 50 MHz).
- SYNC_STAGES, 2: synchronizer depth on the sampled PS/2 lines.

Ports:
- i_clk  in  1  system clock, 50 MHz
- i_rst  in  1  asynchronous, active-high reset
- i_valid  in  1  request to send i_data
- i_data  in  8  command byte
- o_ready  out  1  high in IDLE only; the transfer is accepted when i_valid && o_ready
- i_ps2_clk  in  1  raw ps2_clk pad value
- i_ps2_data  in  1  raw ps2_data pad value
- o_ps2_clk_oe  out  1  1 = pull ps2_clk low; top level drives ps2_clk = oe ? 0 : 'z
- o_ps2_data_oe  out  1  1 = pull ps2_data low
- o_busy  out  1  high outside IDLE; Mouse must discard bits while o_busy is high
- o_done  out  1  one-cycle pulse when a transfer ends (success, NACK or timeout)
- o_ack_ok  out  1  valid with o_done; 1 = device ACK seen
- o_timeout  out  1  valid with o_done; 1 = transfer aborted by timeout

Behaviour:
- Reset (async, immediate):
  - state = IDLE; o_ps2_clk_oe = o_ps2_data_oe = 0 (both lines released).
  - o_ready = 1; o_busy = o_done = o_ack_ok = o_timeout = 0.
  - Counters and shift register cleared.
  - A reset mid-transfer releases both lines in the same cycle; no partial completion pulse is generated.
- Line sampling:
  - i_ps2_clk and i_ps2_data each pass through SYNC_STAGES flops.
  - fall = previous synced clk && !current synced clk.
  - A fall is recognised SYNC_STAGES+1 cycles after the pad edge.
- Latch on accept:
  - shift[9:0] = {1'b1 (stop), ~^i_data (odd parity), i_data}.
  - The shift register is sent LSB first.
  - Parity is odd over the data plus parity bit.
- State machine:
  - IDLE:
    - On accept: clk_oe = 1, cnt = 0, go to INHIBIT.
    - i_valid without o_ready is never possible here; requests raised while busy are ignored, not queued.
  - INHIBIT: clk_oe = 1.
    - When cnt == INHIBIT_CYCLES-1: data_oe = 1 (start bit) and go to REQ. clk_oe stays 1 in this cycle.
    - Total clk_oe assertion before data_oe = exactly INHIBIT_CYCLES cycles.
  - REQ: one cycle with both oe = 1.
    - Next cycle: clk_oe = 0, timeout counter cleared, bitcnt = 0, go to SEND.
  - SEND: on each fall, data_oe = ~shift[bitcnt] and bitcnt++.
    - Falls 1–8 place data bits 0–7, fall 9 places parity, fall 10 places stop (data released).
    - After fall 10, go to ACK.
  - ACK: on the next fall, sample synced data. ack_ok = (data == 0). Go to WAIT_IDLE.
  - WAIT_IDLE: wait for synced clk == 1 and synced data == 1, then go to FINISH.
  - FINISH: one-cycle state. Pulse o_done with o_ack_ok registered, o_timeout = 0. Then go to IDLE.
- Timeout:
  - The counter runs in SEND, ACK and WAIT_IDLE.
  - When it reaches TIMEOUT_CYCLES-1, release both lines and go to FINISH with o_ack_ok = 0, o_timeout = 1.
  - Timeout wins over a fall arriving in the same cycle.
- Simultaneous events: a fall in the same cycle as the REQ→SEND transition is ignored. The device cannot clock sooner than about 100 us, so this is a no-op by construction.
- Arithmetic widths:
  - cnt is $clog2(INHIBIT_CYCLES) bits.
  - The timeout counter is $clog2(TIMEOUT_CYCLES) bits.
  - bitcnt is 4 bits and never exceeds 10.
- Outputs are registered; no combinational path from pad inputs to oe outputs.

Decomposition:
- Package ps2_pkg:
  - State enum for this block.
  - Command constants: PS2_CMD_RESET 8'hFF, PS2_CMD_ENABLE 8'hF4, PS2_CMD_SET_RATE 8'hF3, PS2_RSP_ACK 8'hFA.
  - Function odd_parity(byte).
- Sub-module ps2_line_sync: synchronizer plus falling-edge detector, parameter SYNC_STAGES. It is instantiated twice (clk with edge output, data level only) and is reusable by Mouse.

Test Plan:
- Send 0xF4, device model clocks at 12.5 kHz and ACKs → data_oe pattern on falls 1–10 is data bits 0,0,1,0,1,1,1,1, parity 0, stop released; o_done = 1, o_ack_ok = 1, o_timeout = 0.
- Send 0xFF → eight ones then parity 1; o_ack_ok = 1. Measure clk_oe low for exactly 6000 cycles before data_oe rises.
- Device model holds data high on the ACK edge → o_done with o_ack_ok = 0, o_timeout = 0, and lines released.
- Device never clocks → o_done exactly TIMEOUT_CYCLES cycles after clk release, o_timeout = 1, both oe = 0, o_ready = 1 on the next cycle.
- i_rst asserted mid-SEND at bit 4 → oe outputs drop asynchronously, no o_done, o_ready = 1 after reset; a following 0xF4 transfer completes normally.
- i_valid pulsed with 0x00 while busy sending 0xF4 → ignored; only 0xF4 appears on the line, and exactly one o_done.
